// File: rtl/comparador_if.sv
// comparador_if -- operand/flag bundle for the comparador block.
//   en      : sample operands this cycle
//   a, b    : unsigned operands, WIDTH bits
//   s       : registered a == b
//   s_gt    : registered a >  b
//   s_lt    : registered a <  b
//   s_pulse : one-cycle pulse on a rising match (only with COMPARADOR_EDGE_EN)
// master modport drives operands, slave modport (the comparator) drives flags.
interface comparador_if #(
  parameter int WIDTH = 12
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s;
  logic             s_gt;
  logic             s_lt;
`ifdef COMPARADOR_EDGE_EN
  logic             s_pulse;
`endif

  modport master (
    output en, a, b,
`ifdef COMPARADOR_EDGE_EN
    input  s_pulse,
`endif
    input  s, s_gt, s_lt
  );

  modport slave (
    input  en, a, b,
`ifdef COMPARADOR_EDGE_EN
    output s_pulse,
`endif
    output s, s_gt, s_lt
  );
endinterface

// File: rtl/comparador.sv
// comparador -- registered unsigned magnitude comparator.
// Samples a/b when en=1 and loads one-hot {s, s_gt, s_lt} one clock later;
// flags hold while en=0. Synchronous active-low reset clears all flags.
// Optional macro COMPARADOR_EDGE_EN adds s_pulse: a one-cycle pulse on the
// first cycle s becomes 1.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : comparador_if.slave (en, a, b in; s, s_gt, s_lt[, s_pulse] out)
module comparador #(
  parameter int WIDTH = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  comparador_if.slave   bus
);

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             s_d,    s_q;
  logic             s_gt_d, s_gt_q;
  logic             s_lt_d, s_lt_q;

  assign a_in = bus.a;
  assign b_in = bus.b;

  always_comb begin
    s_d    = s_q;
    s_gt_d = s_gt_q;
    s_lt_d = s_lt_q;
    if (bus.en) begin
      s_d    = (a_in == b_in);
      s_gt_d = (a_in >  b_in);
      s_lt_d = (a_in <  b_in);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q    <= 1'b0;
      s_gt_q <= 1'b0;
      s_lt_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      s_gt_q <= s_gt_d;
      s_lt_q <= s_lt_d;
    end
  end

  assign bus.s    = s_q;
  assign bus.s_gt = s_gt_q;
  assign bus.s_lt = s_lt_q;

`ifdef COMPARADOR_EDGE_EN
  // match_prev_q remembers the match seen on the previous cycle; it resets
  // to 0 so a match on the first enabled sample after reset still pulses.
  logic match_prev_d, match_prev_q;
  logic s_pulse_d,    s_pulse_q;

  always_comb begin
    match_prev_d = s_d;
    s_pulse_d    = s_d & ~match_prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_prev_q <= 1'b0;
      s_pulse_q    <= 1'b0;
    end else begin
      match_prev_q <= match_prev_d;
      s_pulse_q    <= s_pulse_d;
    end
  end

  assign bus.s_pulse = s_pulse_q;
`endif

endmodule

// File: tb/tb_comparador.sv
module tb_comparador;
  localparam int WIDTH = 12;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  comparador_if #(.WIDTH(WIDTH)) bus ();

  comparador #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs at a falling edge, let one rising edge pass, return at
  // the next falling edge where outputs are stable.
  task automatic apply(input logic en_v, input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v);
    bus.en = en_v;
    bus.a  = a_v;
    bus.b  = b_v;
    @(negedge clk);
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, bus.s, bus.s_gt, bus.s_lt};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n  = 1'b0;
    bus.en = 1'b1;
    bus.a  = 12'd1;
    bus.b  = 12'd1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_flags", flags(), 32'b000);
`ifdef COMPARADOR_EDGE_EN
    chk("reset_pulse", {31'd0, bus.s_pulse}, 32'd0);
`endif
    rst_n = 1'b1;

    // equal sweep
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 12'(i), 12'(i));
      chk($sformatf("eq_%0d", i), flags(), 32'b100);
    end

    // off-by-one sweep, both orders
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 12'(i), 12'(i + 1));
      chk($sformatf("lt_%0d", i), flags(), 32'b001);
      apply(1'b1, 12'(i + 1), 12'(i));
      chk($sformatf("gt_%0d", i), flags(), 32'b010);
    end

    // extremes, no wrap-around
    apply(1'b1, 12'hFFF, 12'hFFF); chk("ext_eq",   flags(), 32'b100);
    apply(1'b1, 12'hFFF, 12'hFFE); chk("ext_gt",   flags(), 32'b010);
    apply(1'b1, 12'h000, 12'hFFF); chk("ext_lt",   flags(), 32'b001);
    apply(1'b1, 12'hFFF, 12'h000); chk("ext_nowrap", flags(), 32'b010);

    // hold with en=0
    apply(1'b1, 12'd5, 12'd5); chk("hold_pre", flags(), 32'b100);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 12'd5, 12'd6);
      chk($sformatf("hold_%0d", i), flags(), 32'b100);
    end
    apply(1'b1, 12'd5, 12'd6); chk("hold_release", flags(), 32'b001);

    // mid-operation reset
    apply(1'b1, 12'd7, 12'd7); chk("rst_pre", flags(), 32'b100);
    rst_n = 1'b0;
    apply(1'b1, 12'd7, 12'd7); chk("rst_clear", flags(), 32'b000);
`ifdef COMPARADOR_EDGE_EN
    chk("rst_clear_pulse", {31'd0, bus.s_pulse}, 32'd0);
`endif
    rst_n = 1'b1;
    apply(1'b1, 12'd7, 12'd7); chk("rst_first", flags(), 32'b100);
`ifdef COMPARADOR_EDGE_EN
    chk("rst_first_pulse", {31'd0, bus.s_pulse}, 32'd1);

    // edge pulse
    apply(1'b1, 12'd3, 12'd4); chk("edge_neq", {31'd0, bus.s_pulse}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 12'd3, 12'd3);
      chk($sformatf("edge_hold_%0d", i), {31'd0, bus.s_pulse}, (i == 0) ? 32'd1 : 32'd0);
    end
    apply(1'b1, 12'd3, 12'd4); chk("edge_fall", {31'd0, bus.s_pulse}, 32'd0);
    apply(1'b1, 12'd3, 12'd3); chk("edge_second", {31'd0, bus.s_pulse}, 32'd1);
    apply(1'b0, 12'd3, 12'd3); chk("edge_en_low", {31'd0, bus.s_pulse}, 32'd0);
    chk("edge_en_low_s", flags(), 32'b100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/comparador.md
COMPARADOR -- requirements
Module: comparador

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 12, operand width in bits; legal values 1..32.
REQ-002 Clock and reset SHALL be a single clock and a synchronous, active-low reset.
REQ-003 Port: clk  input  1  rising-edge clock; all state updates on this edge.
REQ-004 Port: rst_n  input  1  synchronous, active-low reset.
REQ-005 Port: en  input  1  compare enable; 1 = sample operands this cycle.
REQ-006 Port: a  input  WIDTH  first operand (e.g. current time).
REQ-007 Port: b  input  WIDTH  second operand (e.g. alarm time).
REQ-008 Port: s  output  WIDTH-independent 1  registered equality flag; 1 when sampled a == b.
REQ-009 Port: s_gt  output  1  registered flag; 1 when sampled a > b, unsigned.
REQ-010 Port: s_lt  output  1  registered flag; 1 when sampled a < b, unsigned.
REQ-011 Port: s_pulse  output  1  present only with COMPARADOR_EDGE_EN; one-cycle pulse on match rising edge.

Function
REQ-012 On each rising clk edge with rst_n=1 and en=1, s, s_gt and s_lt SHALL load the comparison of the current a and b.
REQ-013 Latency SHALL be exactly one clock from operand sample to flag update; no combinational path from a/b to any output.
REQ-014 Exactly one of s, s_gt, s_lt SHALL be 1 at any time after the first enabled sample following reset.
REQ-015 Comparison SHALL be unsigned over all WIDTH bits; no wrap-around or modular equality (a=12'hFFF, b=12'h000 gives s_gt=1).
REQ-016 With en=0, all flags SHALL hold their previous values regardless of a and b.
REQ-017 Operands changing every cycle SHALL be tracked cycle by cycle with no missed samples while en=1.
REQ-018 The block SHALL NOT latch a match; s falls one cycle after operands become unequal.

Reset
REQ-019 While rst_n=0 at a rising clk edge, s, s_gt, s_lt and s_pulse SHALL be 0 on the following cycle, overriding en.
REQ-020 The internal previous-match register for edge detection SHALL reset to 0, so a match present at the first enabled sample after reset produces a pulse.
REQ-021 Reset asserted mid-operation SHALL clear all flags at the next edge; the first post-reset sample follows normal rules.

Configuration
REQ-022 Macro COMPARADOR_EDGE_EN SHALL, when defined, add port s_pulse and its previous-match register.
REQ-023 With COMPARADOR_EDGE_EN, s_pulse SHALL be 1 for exactly one cycle when s transitions 0 to 1, and 0 otherwise, including while en=0.
REQ-024 Without COMPARADOR_EDGE_EN, s_pulse and its register SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-025 Equal sweep: en=1, a=b=i for i=0..15, one value per cycle -> s=1, s_gt=0, s_lt=0 one cycle after each value.
REQ-026 Off-by-one sweep: en=1, a=i, b=i+1 for i=0..15 -> s=0, s_lt=1 each cycle; swap operands -> s_gt=1.
REQ-027 Extremes: a=12'hFFF, b=12'hFFF -> s=1; a=12'hFFF, b=12'hFFE -> s_gt=1; a=0, b=12'hFFF -> s_lt=1.
REQ-028 Hold: sample a=b=5 (s=1), drop en, set b=6 for 3 cycles -> s stays 1; raise en -> s=0, s_lt=1 next cycle.
REQ-029 Reset: with s=1, assert rst_n=0 for one edge -> all flags 0; release with a=b=7 -> s=1 one cycle after first enabled edge.
REQ-030 Edge (COMPARADOR_EDGE_EN): a=b=3 held 4 cycles -> s_pulse=1 only on first s=1 cycle; b=4 then b=3 -> second single pulse.
